mode_pulse_gen: RTL and testbench
=================================

# mode_pulse_gen

Front end that drives the press/release mode-controller inputs from two raw, bouncy, asynchronous pushbuttons. It synchronizes and debounces each button, detects a clean press, and issues a single-cycle `p` or `r` strobe to the mode FSM. It uses the controller's `m` output as feedback so it never issues a redundant request. It sits between board I/O and the mode controller, on the same clock.

## Interface
- `DB_CYCLES`, default 4: consecutive stable synchronized samples required to accept a level change. Legal range is ≥ 2.
- `clk`  in  1  system clock; all logic samples on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_p`  in  1  raw "enter mode" button. Asynchronous, bouncy, active-high.
- `btn_r`  in  1  raw "leave mode" button. Asynchronous, bouncy, active-high.
- `m`  in  1  current mode from the controller (1 = in mode).
- `p`  out  1  one-cycle request to enter mode. Registered.
- `r`  out  1  one-cycle request to leave mode. Registered.

## Operation
- Each button has its own path: a 2-flop synchronizer, then a debounce FSM with a counter of width `$clog2(DB_CYCLES)`. The synchronized level is called `s`.
- Debounce FSM states and transitions:
  - `IDLE`: if `s`=1, go to `BOUNCE_IN` and set cnt=0.
  - `BOUNCE_IN`:
    - if `s`=0, go to `IDLE`;
    - if `s`=1 and cnt=`DB_CYCLES`-1, go to `HELD` and assert the press strobe (combinational) in that cycle;
    - otherwise increment cnt.
  - `HELD`: if `s`=0, go to `BOUNCE_OUT` and set cnt=0.
  - `BOUNCE_OUT`:
    - if `s`=1, go to `HELD` (no new strobe);
    - if `s`=0 and cnt=`DB_CYCLES`-1, go to `IDLE`;
    - otherwise increment cnt.
- Only a press generates a strobe. A release never does, and a long hold gives exactly one strobe.
- Output registers:
  - `p` <= `sp` & ~`sr` & ~`m`
  - `r` <= `sr` & ~`sp` & `m`
  - `sp` and `sr` are the press strobes of the two paths.
- Required boundary behaviour:
  - A press that would be redundant (`p` while `m`=1, `r` while `m`=0) is discarded, not queued.
  - If both strobes occur in the same cycle, both are discarded and neither output pulses.
  - `p` and `r` are never high together. Each pulse is exactly 1 cycle wide.
  - A glitch shorter than `DB_CYCLES` synchronized cycles produces no strobe, in either direction.
- Reset:
  - All synchronizer flops, FSMs (to `IDLE`), counters, `p` and `r` clear to 0 immediately.
  - A button still held when reset deasserts is treated as a new press: it pulses after full debounce.

## Timing
- Edge 0 is the first rising edge that samples a raw button high, with the button then held stable.
- Latency:
  - Edge 1: synchronizer output `s` = 1.
  - Edge 2: FSM in `BOUNCE_IN`, cnt=0.
  - The strobe is asserted in the cycle before edge `DB_CYCLES`+2.
  - `p`/`r` are high from edge `DB_CYCLES`+2 for one cycle. With the default, that is edge 6.
- The `m` value sampled is the one present at that same edge. The controller's registered `m` change follows one edge after the pulse.
- Release recovery:
  - After the raw button drops, the FSM returns to `IDLE` at edge `DB_CYCLES`+2 relative to the first low sample.
  - A new press can then be accepted.
- No combinational path from any input to `p` or `r`.

## Structure
- Package `mode_pkg` holds:
  - the debounce state typedef `dbstate_t` {`IDLE`, `BOUNCE_IN`, `HELD`, `BOUNCE_OUT`}, as a 2-bit enum;
  - the default debounce constant.
- Sub-module `mode_debounce`: synchronizer, debounce FSM and counter. It has parameter `DB_CYCLES`, ports `clk`, `reset`, `btn` and `press` (the combinational strobe). It is instantiated twice.
- The top level holds the gating/arbitration logic and the `p`/`r` output registers.

## Test plan
All scenarios use `DB_CYCLES`=4.
- **Clean press, enter mode:** `m`=0; `btn_p` rises before edge 0 and is held 20 cycles. Required: `p`=1 only in the cycle after edge 6, `r`=0 throughout, exactly one pulse.
- **Bounce rejection:** `btn_p` toggles 1,0,1,1,0 on successive edges, then stays 0. Required: `p` never asserts and the FSM ends in `IDLE`.
- **Redundant request dropped:** `m`=1, clean `btn_p` press. Required: no `p`. Then a clean `btn_r` press gives `r`=1 for one cycle at edge 6.
- **Simultaneous presses:** `btn_p` and `btn_r` rise on the same edge, with `m` = 0 and then `m` = 1. Required: neither `p` nor `r` pulses in either case.
- **Release glitch while held:** hold `btn_p`, wait for the pulse, drop it for 2 cycles, then re-raise it. Required: no second `p`. A full release of ≥ 6 cycles followed by a new press gives a second pulse.
- **Reset mid-debounce:** assert `reset` at edge 4 of a press, release it at edge 6 with the button still held. Required: `p`/`r` stay 0 during reset, and `p` pulses `DB_CYCLES`+2 edges after the first post-reset sample.

Source files
------------

// File: rtl/mode_pkg.sv
// Shared types and defaults for the mode pulse generator front end.
package mode_pkg;

  localparam int DB_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BOUNCE_IN  = 2'd1,
    HELD       = 2'd2,
    BOUNCE_OUT = 2'd3
  } dbstate_t;

endpackage

// File: rtl/mode_debounce.sv
// Per-button path: two-flop synchronizer followed by a debounce FSM that
// emits a single combinational strobe when a press has been stable long enough.
//
// state      | meaning
// IDLE       | button released and stable
// BOUNCE_IN  | button seen high, counting stable high samples
// HELD       | press accepted, button held
// BOUNCE_OUT | button seen low, counting stable low samples
module mode_debounce
  import mode_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_a;
  logic          s;
  dbstate_t      state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= btn;
      s      <= sync_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            state <= BOUNCE_IN;
            cnt   <= '0;
          end
        end
        BOUNCE_IN: begin
          if (!s)                   state <= IDLE;
          else if (cnt == CNT_LAST) state <= HELD;
          else                      cnt   <= cnt + 1'b1;
        end
        HELD: begin
          if (!s) begin
            state <= BOUNCE_OUT;
            cnt   <= '0;
          end
        end
        BOUNCE_OUT: begin
          // A return to high while releasing is the same press, so no strobe.
          if (s)                    state <= HELD;
          else if (cnt == CNT_LAST) state <= IDLE;
          else                      cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign press = (state == BOUNCE_IN) && s && (cnt == CNT_LAST);

endmodule

// File: rtl/mode_pulse_gen.sv
// Debounces the enter/leave buttons and issues single-cycle p/r requests,
// suppressing requests that the current mode makes redundant.
module mode_pulse_gen
  import mode_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_p,
  input  logic btn_r,
  input  logic m,
  output logic p,
  output logic r
);

  logic sp;
  logic sr;

  mode_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_p (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_p),
    .press (sp)
  );

  mode_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_r (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_r),
    .press (sr)
  );

  // Simultaneous strobes cancel each other; redundant requests are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= 1'b0;
      r <= 1'b0;
    end else begin
      p <= sp & ~sr & ~m;
      r <= sr & ~sp &  m;
    end
  end

endmodule

// File: tb/tb_mode_pulse_gen.sv
// Directed bench for mode_pulse_gen with DB_CYCLES = 4.
module tb_mode_pulse_gen;
  import mode_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic btn_p;
  logic btn_r;
  logic m;
  logic p;
  logic r;

  int vectors = 0;
  int miscompares = 0;

  mode_pulse_gen #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .btn_p (btn_p),
    .btn_r (btn_r),
    .m     (m),
    .p     (p),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    btn_p = 1'b0;
    btn_r = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_p = 1'b0;
    btn_r = 1'b0;
    m     = 1'b0;
    tick();
    tick();
    vectors++;
    if (p !== 1'b0 || r !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got p=%b r=%b want p=0 r=0", p, r);
    end
    vectors++;
    if (dut.u_deb_p.state !== IDLE || dut.u_deb_r.state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d/%0d want 0/0", dut.u_deb_p.state, dut.u_deb_r.state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_press();
    logic exp_p;
    m = 1'b0;
    btn_p = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      exp_p = (e == 6);
      vectors++;
      if (p !== exp_p || r !== 1'b0) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: got p=%b r=%b want p=%b r=0", e, p, r, exp_p);
      end
    end
    gap(8);
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b01101;
    m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_p = pat[i];
      tick();
      vectors++;
      if (p !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce step %0d: got p=%b want 0", i, p);
      end
    end
    btn_p = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (p !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce tail %0d: got p=%b want 0", i, p);
      end
    end
    vectors++;
    if (dut.u_deb_p.state !== IDLE) begin
      miscompares++;
      $display("FAIL bounce_state: got %0d want 0", dut.u_deb_p.state);
    end
  endtask

  task automatic test_redundant();
    logic exp_r;
    m = 1'b1;
    btn_p = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      vectors++;
      if (p !== 1'b0 || r !== 1'b0) begin
        miscompares++;
        $display("FAIL redundant_p edge %0d: got p=%b r=%b want p=0 r=0", e, p, r);
      end
    end
    gap(8);
    btn_r = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      exp_r = (e == 6);
      vectors++;
      if (r !== exp_r || p !== 1'b0) begin
        miscompares++;
        $display("FAIL leave_press edge %0d: got p=%b r=%b want p=0 r=%b", e, p, r, exp_r);
      end
    end
    gap(8);
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 2; k++) begin
      m = (k == 1);
      btn_p = 1'b1;
      btn_r = 1'b1;
      for (int e = 0; e < 20; e++) begin
        tick();
        vectors++;
        if (p !== 1'b0 || r !== 1'b0) begin
          miscompares++;
          $display("FAIL simultaneous m=%0d edge %0d: got p=%b r=%b want p=0 r=0", k, e, p, r);
        end
      end
      gap(8);
    end
  endtask

  task automatic test_release_glitch();
    logic exp_p;
    m = 1'b0;
    btn_p = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      exp_p = (e == 6);
      vectors++;
      if (p !== exp_p) begin
        miscompares++;
        $display("FAIL glitch_first edge %0d: got p=%b want %b", e, p, exp_p);
      end
    end
    btn_p = 1'b0;
    tick();
    tick();
    btn_p = 1'b1;
    for (int e = 0; e < 14; e++) begin
      tick();
      vectors++;
      if (p !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_repress edge %0d: got p=%b want 0", e, p);
      end
    end
    gap(8);
    btn_p = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      exp_p = (e == 6);
      vectors++;
      if (p !== exp_p) begin
        miscompares++;
        $display("FAIL glitch_second edge %0d: got p=%b want %b", e, p, exp_p);
      end
    end
    gap(8);
  endtask

  task automatic test_reset_mid();
    logic exp_p;
    m = 1'b0;
    btn_p = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (dut.u_deb_p.state !== IDLE || p !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got state=%0d p=%b want state=0 p=0", dut.u_deb_p.state, p);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (p !== 1'b0 || r !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_hold %0d: got p=%b r=%b want p=0 r=0", i, p, r);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_p = (e == 6);
      vectors++;
      if (p !== exp_p) begin
        miscompares++;
        $display("FAIL reset_mid_press edge %0d: got p=%b want %b", e, p, exp_p);
      end
    end
    gap(8);
    btn_p = 1'b1;
    for (int e = 0; e < 7; e++) tick();
    vectors++;
    if (p !== 1'b1) begin
      miscompares++;
      $display("FAIL pulse_before_reset: got p=%b want 1", p);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (p !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_clears_p: got p=%b want 0", p);
    end
    tick();
    reset = 1'b0;
    gap(8);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_redundant();
    test_simultaneous();
    test_release_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
